// File: rtl/p09_spi_pkg.sv
// Shared constants, frame state type and width helpers for the SPI slave.
package p09_spi_pkg;

  localparam int MODE0 = 0;
  localparam int MODE1 = 1;
  localparam int MODE2 = 2;
  localparam int MODE3 = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_t;

  function automatic int idx_width(input int max_words);
    return (max_words > 2) ? $clog2(max_words) : 1;
  endfunction

endpackage

// File: rtl/p09_spi_slave_gen_if.sv
// SPI pin bundle between the pad ring (master side) and the slave core.
interface p09_spi_slave_gen_if;
  logic sck;
  logic ss;
  logic mosi;
  logic miso;
  logic miso_en;

  modport master (output sck, ss, mosi, input miso, miso_en);
  modport slave  (input sck, ss, mosi, output miso, miso_en);
endinterface

// File: rtl/p09_spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised output.
module p09_spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
      flush_q <= '0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], din};
      prev_q  <= sync_q[STAGES-1];
      flush_q <= {flush_q[STAGES-1:0], 1'b1};
    end
  end

  // Edges are suppressed until both compared samples come from the pin,
  // so a level differing from RST_VAL across reset is not seen as an edge.
  assign rise = flush_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
  assign fall = flush_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/p09_spi_slave_gen.sv
// Parametrised SPI slave: snapshots game state onto miso, collects command words.
//   state  | meaning
//   IDLE   | ss high, sck ignored, miso pad disabled
//   ACTIVE | frame in progress, shifting snapshot out and words in
module p09_spi_slave_gen
  import p09_spi_pkg::*;
#(
  parameter int  STATE_SIZE  = 41,
  parameter int  WORD_W      = 16,
  parameter int  MAX_WORDS   = 4,
  parameter int  SPI_MODE    = MODE0,
  parameter int  SYNC_STAGES = 2,
  localparam int IDX_W       = idx_width(MAX_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  p09_spi_slave_gen_if.slave    spi,
  input  logic [STATE_SIZE-1:0] state,
  output logic [WORD_W-1:0]     write_value,
  output logic [IDX_W-1:0]      write_index,
  output logic                  write_en,
  output logic                  start_transaction,
  output logic                  end_transaction,
  output logic                  short_frame,
  output logic                  overflow
);
  localparam logic CPOL   = (SPI_MODE == MODE2) || (SPI_MODE == MODE3);
  localparam logic CPHA   = (SPI_MODE == MODE1) || (SPI_MODE == MODE3);
  localparam int   BIT_W  = $clog2(WORD_W);
  localparam int   WCNT_W = $clog2(MAX_WORDS + 1);

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s, lead_edge, trail_edge, sample_edge, shift_edge;

  frame_state_t          fsm_q, fsm_d;
  logic [STATE_SIZE-1:0] snap_q;
  logic [WORD_W-2:0]     shreg_q;
  logic [WORD_W-1:0]     shreg_d;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [WCNT_W-1:0]     word_cnt_q;
  logic                  first_shift_q;

  p09_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
    .clk(clk), .rst(rst), .din(spi.sck), .rise(sck_rise), .fall(sck_fall)
  );

  p09_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(spi.ss), .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
  end

  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign shreg_d     = {shreg_q, mosi_s};

  assign spi.miso    = snap_q[STATE_SIZE-1];
  assign spi.miso_en = (fsm_q == ACTIVE);

  always_comb begin
    fsm_d             = fsm_q;
    start_transaction = 1'b0;
    end_transaction   = 1'b0;
    case (fsm_q)
      IDLE: if (ss_fall) begin
        fsm_d             = ACTIVE;
        start_transaction = 1'b1;
      end
      ACTIVE: if (ss_rise) begin
        fsm_d           = IDLE;
        end_transaction = 1'b1;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= IDLE;
      snap_q        <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      first_shift_q <= 1'b0;
      write_value   <= '0;
      write_index   <= '0;
      write_en      <= 1'b0;
      short_frame   <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      write_en <= 1'b0;
      if (start_transaction) begin
        snap_q        <= state;
        bit_cnt_q     <= '0;
        word_cnt_q    <= '0;
        short_frame   <= 1'b0;
        overflow      <= 1'b0;
        first_shift_q <= CPHA;
      end else if (end_transaction) begin
        short_frame <= (bit_cnt_q != '0);
        bit_cnt_q   <= '0;
      end else if (fsm_q == ACTIVE) begin
        // In CPHA=1 the first leading edge would otherwise push the MSB out
        // before the master has sampled it.
        if (shift_edge) begin
          if (first_shift_q) first_shift_q <= 1'b0;
          else               snap_q <= {snap_q[STATE_SIZE-2:0], 1'b1};
        end
        if (sample_edge) begin
          shreg_q <= shreg_d[WORD_W-2:0];
          if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
            bit_cnt_q <= '0;
            if (word_cnt_q < WCNT_W'(MAX_WORDS)) begin
              write_en    <= 1'b1;
              write_value <= shreg_d;
              write_index <= word_cnt_q[IDX_W-1:0];
              word_cnt_q  <= word_cnt_q + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/p09_spi_slave_gen.md
Name: p09_spi_slave_gen

Overview:
Parametrised SPI slave for the breakout game; successor to the fixed mode-0, single-16-bit-word interface.
- Supports all four SPI modes, any word width, and up to MAX_WORDS words per ss-low frame.
- Snapshots the game state on frame start and shifts it out on miso.
- Adds input synchronisers, a word index per write, and frame-end and error reporting.
- Sits between the chip pins and the game register file / command decoder.

Parameters:
- STATE_SIZE, 41, width of the game-state snapshot shifted out on miso.
- WORD_W, 16, bits per received command word (>=2).
- MAX_WORDS, 4, words accepted per frame; later words are dropped (>=1).
- SPI_MODE, 0, {CPOL,CPHA} as 0..3.
- SYNC_STAGES, 2, synchroniser flops on sck/ss/mosi (>=2).
- IDX_W, derived localparam: max(1, clog2(MAX_WORDS)).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- sck  in  1  SPI clock, asynchronous to clk.
- ss  in  1  slave select, active low, asynchronous.
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- miso_en  out  1  pad output enable.
- state  in  STATE_SIZE  game state, sampled at frame start.
- write_value  out  WORD_W  last completed word, held until the next word completes.
- write_index  out  IDX_W  word position of write_value within the frame.
- write_en  out  1  one-cycle strobe, word valid.
- start_transaction  out  1  one-cycle pulse on detected ss fall.
- end_transaction  out  1  one-cycle pulse on detected ss rise during a frame.
- short_frame  out  1  frame ended mid-word; sticky until next start.
- overflow  out  1  more than MAX_WORDS words sent; sticky until next start.

Behaviour:
- sck, ss and mosi each pass through SYNC_STAGES flops plus one edge-detect flop.
- Synchroniser reset values: ss=1, sck=CPOL, mosi=0. Holding ss low through reset must not produce a start.
- Edges are detected from the last two synchronised sck samples.
  - Leading edge: rise if CPOL=0, fall if CPOL=1. Trailing edge is the opposite.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing. The first shift edge of each frame is ignored, so the MSB stays on miso for the first sample.
- Frame FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on ss fall. In that cycle: start_transaction=1; snapshot<=state; bit_cnt, word_cnt, short_frame and overflow cleared.
  - ACTIVE -> IDLE on ss rise. In that cycle: end_transaction=1; short_frame<=(bit_cnt!=0); partial bits discarded.
- Outputs in each state:
  - miso_en=1 only in ACTIVE.
  - miso = snapshot MSB in both states.
  - On each shift edge, the snapshot shifts left and fills with 1, so miso reads 1 once the state is exhausted.
- On a sample edge (ACTIVE only):
  - shreg<={shreg[WORD_W-2:0],mosi}, then bit_cnt increments.
  - When bit_cnt==WORD_W-1, bit_cnt wraps to 0.
  - If word_cnt<MAX_WORDS: next cycle write_en=1, write_value<=completed word, write_index<=word_cnt; word_cnt increments.
  - Otherwise: overflow<=1 and write_en stays 0. word_cnt saturates at MAX_WORDS.
- Latency: write_en asserts exactly one clk after the cycle in which the final-bit sample edge is detected.
- Simultaneous events:
  - ss fall with an sck edge in the same cycle: the ss fall wins and the sck edge is ignored.
  - ss rise with a sample edge: the ss rise wins and the bit is dropped.
- sck edges in IDLE are ignored entirely: no shift, no count.
- rst mid-frame: all registers return to reset values and the frame is abandoned. A new frame needs a fresh ss fall.
- Output reset values: miso=0, miso_en=0, write_value=0, write_index=0, write_en=0, start_transaction=0, end_transaction=0, short_frame=0, overflow=0.
- sck must be at most clk/(2*(SYNC_STAGES+2)); behaviour at faster sck is undefined.

Decomposition:
- Package p09_spi_pkg holds:
  - the SPI mode constants MODE0..MODE3;
  - the FSM state enum (IDLE, ACTIVE);
  - the function deriving IDX_W.
- One sub-module, p09_spi_sync_edge: parametrised synchroniser with rise/fall detection and a reset-value parameter. Instantiated for sck and ss; mosi uses the synchroniser only.

Test Plan:
- Mode 0, single word:
  - Stimulus: state=41'h1_2345_6789_A; ss low; 16 bits of 0xA5C3; ss high.
  - Response: one write_en, write_value=0xA5C3, write_index=0.
  - Response: miso carries the state MSB-first, then 1s.
  - Response: start and end pulses each once; short_frame=0.
- Mode 3, two words:
  - Stimulus: 0x1234 then 0xBEEF in one frame.
  - Response: write_en twice, with indices 0 and 1 and values as sent.
  - Response: miso bit 0 equals state[40] before the first sck edge.
- Mode 1, CPHA=1 first-edge rule:
  - Stimulus: state MSB=1, next bit=0.
  - Response: master samples 1 then 0. The first leading edge must not shift the snapshot.
- Overflow, MAX_WORDS=2:
  - Stimulus: 3 words in one frame.
  - Response: exactly 2 write_en.
  - Response: overflow=1 after the third word, held until the next ss fall, then cleared.
- Short frame:
  - Stimulus: 9 bits then ss high.
  - Response: no write_en; end_transaction=1; short_frame=1.
  - Response: next full frame writes with index 0 and short_frame clears.
- Reset mid-frame:
  - Stimulus: assert rst after 7 bits with ss still low.
  - Response: all outputs return to 0.
  - Response: following bits produce nothing until ss rises and falls again.
